ahb_lite_master: RTL and testbench
==================================

Name: ahb_lite_master

Overview:
- Single-transfer AHB-Lite initiator.
- Converts a simple valid/ready request stream (CPU load/store or DMA engine) into NONSEQ single transfers toward AHB slaves such as the on-chip RAM.
- Address and data phases are pipelined, so back-to-back requests sustain one transfer per cycle with zero-wait slaves.
- Completions return in order on a response strobe.

Parameters:
HPROT, 4'b0011, constant value driven on hprot (non-cacheable, non-bufferable, privileged, data).

Ports:
hclk  in  1  clock; all state changes on rising edge
hreset_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  request accepted at edge where req_valid & req_ready
req_write  in  1  1=write, 0=read
req_size  in  2  0=byte, 1=halfword, 2=word; 3 illegal (caller never drives it)
req_addr  in  32  byte address; caller guarantees natural alignment
req_wdata  in  32  write data, byte-lane placed per AHB little-endian
rsp_valid  out  1  one-cycle completion pulse, no backpressure
rsp_rdata  out  32  hrdata of completed read; 0 for writes
rsp_err  out  1  completion had ERROR response (valid with rsp_valid)
haddr  out  32  AHB address
htrans  out  2  2'b00 IDLE or 2'b10 NONSEQ only
hwrite  out  1  AHB direction
hsize  out  3  {1'b0, req_size}
hburst  out  3  constant 3'b000 (SINGLE)
hprot  out  4  constant HPROT
hwdata  out  32  write data in data phase
hrdata  in  32  read data
hready  in  1  transfer-done / phase advance
hresp  in  2  2'b00 OKAY, 2'b01 ERROR

Behaviour:
- Reset (async, any time including mid-transfer): htrans=IDLE, haddr=0, hwrite=0, hsize=0, hwdata=0, rsp_valid=0, rsp_rdata=0, rsp_err=0. All in-flight transfers dropped, no response generated.
- Two pipeline stages:
  - A: address-phase register; valid when htrans=NONSEQ.
  - D: data-phase register; holds write flag and wdata of the transfer whose address phase completed.
- req_ready = ~A_valid | (hready & ~err_hold). Combinational, so it is low while a pending address phase is stalled.
- Accept edge: A loads haddr/hwrite/hsize from req; htrans=NONSEQ in the next cycle. At the same edge:
  - if A completes (A_valid & hready), it moves to D;
  - if no new request is accepted and A completes, htrans returns to IDLE.
- A completes at an edge where hready=1: hwdata <= stored wdata (write), D_valid <= 1.
- D completes at an edge where D_valid & hready=1:
  - rsp_valid=1 the next cycle;
  - rsp_rdata = hrdata for reads, 0 for writes;
  - rsp_err = (hresp==ERROR), feature dependent.
  - D_valid clears unless A also completed at the same edge.
- Address/control/hwdata held stable while hready=0.
- Latency, zero wait: accept edge T0 -> address phase T0..T1 -> data phase T1..T2 -> rsp_valid high cycle T2..T3. Each slave wait state adds one cycle.
- Throughput: 1 transfer/cycle with continuous req_valid and hready=1.
- Responses are strictly in request order. At most 2 transfers in flight.
- Idle bus: htrans=IDLE; haddr/hwrite/hsize keep last values.

Optional Feature:
- Macro AHB_MST_ERR_EN.
- Defined:
  - Detect first ERROR cycle (D_valid, hresp=ERROR, hready=0).
  - If A_valid, force htrans=IDLE in the following cycle (second ERROR cycle) and set err_hold, keeping the stored request.
  - At the edge with hready=1, D completes with rsp_err=1; err_hold clears and htrans returns to NONSEQ with the same stored address, i.e. the request is re-issued, not dropped.
- Undefined: hresp ignored; rsp_err tied 0; no err_hold logic.

Test Plan:
- Read word 0x0000_0010 from zero-wait slave returning 0xDEAD_BEEF -> htrans NONSEQ one cycle, hsize=3'b010, rsp_valid 2 cycles after accept, rsp_rdata=0xDEAD_BEEF, rsp_err=0.
- Write byte req_addr=0x0000_0003, wdata=0xAA00_0000 -> haddr=0x3, hsize=3'b000, hwrite=1, hwdata=0xAA00_0000 in the cycle after the address phase; rsp_rdata=0.
- Four back-to-back word reads 0x0,0x4,0x8,0xC with req_valid held -> htrans NONSEQ 4 consecutive cycles, 4 consecutive rsp_valid pulses in order, req_ready never low.
- Slave inserts 2 wait states on the first of two writes -> second haddr held stable, req_ready=0 during wait, hwdata held, responses 2 cycles later than zero-wait case.
- With AHB_MST_ERR_EN: write to 0x0 answered ERROR while read 0x4 pending -> htrans=IDLE in second ERROR cycle, rsp_err=1 for write, read 0x4 re-issued, rsp_err=0 for it.
- Assert hreset_n low between address and data phase -> outputs immediately at reset values, no rsp_valid after release, next request behaves as first.

Source files
------------

// File: rtl/ahb_lite_master_if.sv
// ahb_lite_master_if: request/response stream and AHB-Lite bus signals of
// the single-transfer initiator. The master modport is the initiator's view;
// the slave modport is the view of the requester plus the AHB slave.
interface ahb_lite_master_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [3:0]  hprot;
  logic [31:0] hwdata;
  logic [31:0] hrdata;
  logic        hready;
  logic [1:0]  hresp;

  modport master (
    input  req_valid, req_write, req_size, req_addr, req_wdata,
    output req_ready,
    output rsp_valid, rsp_rdata, rsp_err,
    output haddr, htrans, hwrite, hsize, hburst, hprot, hwdata,
    input  hrdata, hready, hresp
  );

  modport slave (
    output req_valid, req_write, req_size, req_addr, req_wdata,
    input  req_ready,
    input  rsp_valid, rsp_rdata, rsp_err,
    input  haddr, htrans, hwrite, hsize, hburst, hprot, hwdata,
    output hrdata, hready, hresp
  );
endinterface

// File: rtl/ahb_lite_master.sv
// ahb_lite_master: single-transfer AHB-Lite initiator. Turns a valid/ready
// request stream into NONSEQ SINGLE transfers with pipelined address (A) and
// data (D) stages; completions return in order as a one-cycle rsp_valid pulse.
// Optional feature macro AHB_MST_ERR_EN: two-cycle ERROR response handling
// (rsp_err reporting, pending address phase withdrawn and re-issued).
module ahb_lite_master #(
  parameter logic [3:0] HPROT = 4'b0011
) (
  input logic               hclk,
  input logic               hreset_n,
  ahb_lite_master_if.master bus
);

  localparam logic [1:0] TRANS_IDLE   = 2'b00;
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;
`ifdef AHB_MST_ERR_EN
  localparam logic [1:0] RESP_ERROR   = 2'b01;
`endif

  // A_HOLD: request kept but withdrawn from the bus during the second ERROR cycle
  typedef enum logic [1:0] {A_IDLE, A_ACTIVE, A_HOLD} a_state_t;

  a_state_t    a_state, a_state_nxt;
  logic        req_ready_c;
  logic        accept;
  logic        a_done;
  logic        d_done;
  logic        err_hold;
  logic [31:0] haddr_q;
  logic        hwrite_q;
  logic [2:0]  hsize_q;
  logic [31:0] a_wdata;
  logic        d_valid;
  logic        d_write;
  logic [31:0] hwdata_q;
  logic        rsp_valid_q;
  logic [31:0] rsp_rdata_q;

  // Address-stage state register
  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) a_state <= A_IDLE;
    else           a_state <= a_state_nxt;
  end

  // Address-stage next state, request handshake and stage-advance strobes
  always_comb begin
    a_state_nxt = a_state;
    err_hold    = (a_state == A_HOLD);
    req_ready_c = (a_state == A_IDLE) | (bus.hready & ~err_hold);
    accept      = bus.req_valid & req_ready_c;
    a_done      = (a_state == A_ACTIVE) & bus.hready;
    d_done      = d_valid & bus.hready;
    unique case (a_state)
      A_IDLE: begin
        if (accept) a_state_nxt = A_ACTIVE;
      end
      A_ACTIVE: begin
        if (accept)      a_state_nxt = A_ACTIVE;
        else if (a_done) a_state_nxt = A_IDLE;
`ifdef AHB_MST_ERR_EN
        else if (d_valid & ~bus.hready & (bus.hresp == RESP_ERROR))
          a_state_nxt = A_HOLD;
`endif
      end
      A_HOLD: begin
        if (bus.hready) a_state_nxt = A_ACTIVE;
      end
      default: a_state_nxt = A_IDLE;
    endcase
  end

  // Address/data pipeline registers and completion capture
  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      haddr_q     <= '0;
      hwrite_q    <= 1'b0;
      hsize_q     <= '0;
      a_wdata     <= '0;
      d_valid     <= 1'b0;
      d_write     <= 1'b0;
      hwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      if (accept) begin
        haddr_q  <= bus.req_addr;
        hwrite_q <= bus.req_write;
        hsize_q  <= {1'b0, bus.req_size};
        a_wdata  <= bus.req_wdata;
      end
      if (a_done) begin
        d_write <= hwrite_q;
        if (hwrite_q) hwdata_q <= a_wdata;
      end
      if (a_done)      d_valid <= 1'b1;
      else if (d_done) d_valid <= 1'b0;
      rsp_valid_q <= d_done;
      if (d_done) rsp_rdata_q <= d_write ? '0 : bus.hrdata;
    end
  end

`ifdef AHB_MST_ERR_EN
  logic rsp_err_q;

  // Error status captured alongside the completing data phase
  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n)   rsp_err_q <= 1'b0;
    else if (d_done) rsp_err_q <= (bus.hresp == RESP_ERROR);
  end

  assign bus.rsp_err = rsp_err_q;
`else
  assign bus.rsp_err = 1'b0;
`endif

  assign bus.req_ready = req_ready_c;
  assign bus.htrans    = (a_state == A_ACTIVE) ? TRANS_NONSEQ : TRANS_IDLE;
  assign bus.haddr     = haddr_q;
  assign bus.hwrite    = hwrite_q;
  assign bus.hsize     = hsize_q;
  assign bus.hburst    = 3'b000;
  assign bus.hprot     = HPROT;
  assign bus.hwdata    = hwdata_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_ahb_lite_master.sv
// tb_ahb_lite_master: directed bench for ahb_lite_master. A transaction-level
// model (request queues plus a scripted slave) predicts the bus and response
// signals every cycle; per-test literal expectations pin latencies and data.
module tb_ahb_lite_master;

  localparam logic [3:0] HPROT_V = 4'b0011;
`ifdef AHB_MST_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic hclk;
  logic hreset_n;

  ahb_lite_master_if bus();

  ahb_lite_master #(.HPROT(HPROT_V)) dut (
    .hclk     (hclk),
    .hreset_n (hreset_n),
    .bus      (bus)
  );

  initial begin
    hclk = 1'b0;
    forever #5 hclk = ~hclk;
  end

  typedef struct {
    logic        write;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          waits;
    bit          err;
    int          acc_cyc;
  } req_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] rdata;
    logic        err;
    int          acc_cyc;
    int          rsp_cyc;
  } log_t;

  req_t        drive_q[$];
  req_t        issue_q[$];
  req_t        dp;
  bit          dp_v;
  int          dp_cyc;
  log_t        rsp_log[$];
  int          total;
  int          bad;
  int          cyc;
  bit          exp_v;
  logic [31:0] exp_rd;
  logic        exp_err;
  bit          hold_exp;
  logic [31:0] last_addr;
  logic        p_req_valid;
  logic        p_req_ready;
  logic        p_hready;
  logic [1:0]  p_htrans;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] rd_data(input logic [31:0] a);
    return (a == 32'h0000_0010) ? 32'hDEAD_BEEF : (32'hC0DE_0000 | a);
  endfunction

  task automatic push(input logic w, input logic [1:0] s, input logic [31:0] a,
                      input logic [31:0] d, input int waits, input bit err);
    req_t r;
    r.write   = w;
    r.size    = s;
    r.addr    = a;
    r.wdata   = d;
    r.waits   = waits;
    r.err     = err;
    r.acc_cyc = 0;
    drive_q.push_back(r);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((drive_q.size() > 0 || issue_q.size() > 0 || dp_v) && n < 200) begin
      @(posedge hclk);
      n++;
    end
    total++;
    if (n >= 200) begin
      bad++;
      $display("FAIL timeout: transfers still pending after %0d cycles, want idle", n);
    end
    repeat (2) @(posedge hclk);
  endtask

  task automatic start_test();
    @(posedge hclk);
    rsp_log.delete();
  endtask

  // Cycle engine: advance the model over the edge just passed, check outputs,
  // drive requester and slave inputs, then sample the combinational outputs.
  initial begin
    req_t        r;
    log_t        l;
    logic        exp_ready;
    logic [1:0]  exp_trans;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_size  = 2'b00;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.hready    = 1'b1;
    bus.hresp     = 2'b00;
    bus.hrdata    = 32'h0BAD_F00D;
    dp_v = 1'b0; dp_cyc = 0; cyc = 0; exp_v = 1'b0; hold_exp = 1'b0; last_addr = '0;
    p_req_valid = 1'b0; p_req_ready = 1'b0; p_hready = 1'b1; p_htrans = 2'b00;
    forever begin
      @(negedge hclk);
      cyc++;
      if (!hreset_n) begin
        drive_q.delete();
        issue_q.delete();
        dp_v = 1'b0; exp_v = 1'b0; hold_exp = 1'b0; last_addr = '0;
        p_req_valid = 1'b0; p_req_ready = 1'b0; p_hready = 1'b1; p_htrans = 2'b00;
        check("rst_htrans", 32'(bus.htrans), 32'h0);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        bus.req_valid = 1'b0;
        bus.hready    = 1'b1;
        bus.hresp     = 2'b00;
        continue;
      end
      // data phase completion / wait
      exp_v    = 1'b0;
      hold_exp = 1'b0;
      if (dp_v) begin
        if (p_hready) begin
          exp_v   = 1'b1;
          exp_rd  = dp.write ? 32'h0 : rd_data(dp.addr);
          exp_err = ERR_EN & dp.err;
          l.addr = dp.addr; l.rdata = exp_rd; l.err = exp_err;
          l.acc_cyc = dp.acc_cyc; l.rsp_cyc = cyc;
          rsp_log.push_back(l);
          dp_v = 1'b0;
        end else begin
          if (ERR_EN && dp.err && dp_cyc == 0 && issue_q.size() > 0) hold_exp = 1'b1;
          dp_cyc++;
        end
      end
      // address phase completion
      if (p_htrans == 2'b10 && p_hready && issue_q.size() > 0) begin
        dp     = issue_q.pop_front();
        dp_v   = 1'b1;
        dp_cyc = 0;
      end
      // request acceptance
      if (p_req_valid && p_req_ready && drive_q.size() > 0) begin
        r = drive_q.pop_front();
        r.acc_cyc = cyc;
        issue_q.push_back(r);
        last_addr = r.addr;
      end
      // registered response outputs
      check("rsp_valid", 32'(bus.rsp_valid), 32'(exp_v));
      if (exp_v) begin
        check("rsp_rdata", bus.rsp_rdata, exp_rd);
        check("rsp_err", 32'(bus.rsp_err), 32'(exp_err));
      end
      // drive requester
      if (drive_q.size() > 0) begin
        bus.req_valid = 1'b1;
        bus.req_write = drive_q[0].write;
        bus.req_size  = drive_q[0].size;
        bus.req_addr  = drive_q[0].addr;
        bus.req_wdata = drive_q[0].wdata;
      end else begin
        bus.req_valid = 1'b0;
        bus.req_addr  = 32'hFFFF_FFF0;
        bus.req_wdata = 32'h5555_5555;
      end
      // drive slave
      if (dp_v) begin
        if (dp.err) begin
          bus.hready = (dp_cyc >= 1);
          bus.hresp  = 2'b01;
        end else begin
          bus.hready = (dp_cyc >= dp.waits);
          bus.hresp  = 2'b00;
        end
        bus.hrdata = dp.write ? 32'h0BAD_F00D : rd_data(dp.addr);
      end else begin
        bus.hready = 1'b1;
        bus.hresp  = 2'b00;
        bus.hrdata = 32'h0BAD_F00D;
      end
      #1;
      exp_ready = (issue_q.size() == 0) || (bus.hready && !hold_exp);
      exp_trans = (issue_q.size() > 0 && !hold_exp) ? 2'b10 : 2'b00;
      check("req_ready", 32'(bus.req_ready), 32'(exp_ready));
      check("htrans", 32'(bus.htrans), 32'(exp_trans));
      if (issue_q.size() > 0) begin
        check("haddr", bus.haddr, issue_q[0].addr);
        check("hwrite", 32'(bus.hwrite), 32'(issue_q[0].write));
        check("hsize", 32'(bus.hsize), 32'({1'b0, issue_q[0].size}));
      end else begin
        check("idle_haddr", bus.haddr, last_addr);
      end
      check("hburst", 32'(bus.hburst), 32'h0);
      check("hprot", 32'(bus.hprot), 32'(HPROT_V));
      if (dp_v && dp.write) check("hwdata", bus.hwdata, dp.wdata);
      p_req_valid = bus.req_valid;
      p_req_ready = bus.req_ready;
      p_hready    = bus.hready;
      p_htrans    = bus.htrans;
    end
  end

  // Directed tests with literal expectations
  initial begin
    int n;
    logic [31:0] rd4 [4];
    rd4[0] = 32'hC0DE_0000; rd4[1] = 32'hC0DE_0004;
    rd4[2] = 32'hC0DE_0008; rd4[3] = 32'hC0DE_000C;
    total = 0;
    bad = 0;
    hreset_n = 1'b0;
    repeat (3) @(posedge hclk);
    #1;
    check("reset_haddr", bus.haddr, 32'h0);
    check("reset_hwdata", bus.hwdata, 32'h0);
    check("reset_rsp_rdata", bus.rsp_rdata, 32'h0);
    @(negedge hclk);
    #2 hreset_n = 1'b1;

    // single word read
    start_test();
    push(1'b0, 2'd2, 32'h0000_0010, 32'h0, 0, 1'b0);
    wait_idle();
    check("t1_count", 32'(rsp_log.size()), 32'd1);
    if (rsp_log.size() >= 1) begin
      check("t1_rdata", rsp_log[0].rdata, 32'hDEAD_BEEF);
      check("t1_err", 32'(rsp_log[0].err), 32'h0);
      check("t1_latency", 32'(rsp_log[0].rsp_cyc - rsp_log[0].acc_cyc), 32'd2);
    end

    // byte write
    start_test();
    push(1'b1, 2'd0, 32'h0000_0003, 32'hAA00_0000, 0, 1'b0);
    wait_idle();
    check("t2_count", 32'(rsp_log.size()), 32'd1);
    if (rsp_log.size() >= 1) begin
      check("t2_rdata", rsp_log[0].rdata, 32'h0);
      check("t2_latency", 32'(rsp_log[0].rsp_cyc - rsp_log[0].acc_cyc), 32'd2);
    end

    // four back-to-back word reads
    start_test();
    for (int i = 0; i < 4; i++) push(1'b0, 2'd2, 32'(i * 4), 32'h0, 0, 1'b0);
    wait_idle();
    check("t3_count", 32'(rsp_log.size()), 32'd4);
    if (rsp_log.size() >= 4) begin
      for (int i = 0; i < 4; i++) begin
        check("t3_rdata", rsp_log[i].rdata, rd4[i]);
        check("t3_acc_seq", 32'(rsp_log[i].acc_cyc - rsp_log[0].acc_cyc), 32'(i));
        check("t3_rsp_seq", 32'(rsp_log[i].rsp_cyc - rsp_log[0].acc_cyc), 32'(i + 2));
      end
    end

    // two writes, first with two wait states
    start_test();
    push(1'b1, 2'd2, 32'h0000_0040, 32'h1111_2222, 2, 1'b0);
    push(1'b1, 2'd1, 32'h0000_0046, 32'h3344_0000, 0, 1'b0);
    wait_idle();
    check("t4_count", 32'(rsp_log.size()), 32'd2);
    if (rsp_log.size() >= 2) begin
      check("t4_acc2", 32'(rsp_log[1].acc_cyc - rsp_log[0].acc_cyc), 32'd1);
      check("t4_lat1", 32'(rsp_log[0].rsp_cyc - rsp_log[0].acc_cyc), 32'd4);
      check("t4_lat2", 32'(rsp_log[1].rsp_cyc - rsp_log[0].acc_cyc), 32'd5);
    end

    // write answered with ERROR while a read is pending
    start_test();
    push(1'b1, 2'd2, 32'h0000_0000, 32'hCAFE_0001, 0, 1'b1);
    push(1'b0, 2'd2, 32'h0000_0004, 32'h0, 0, 1'b0);
    wait_idle();
    check("t5_count", 32'(rsp_log.size()), 32'd2);
    if (rsp_log.size() >= 2) begin
      check("t5_werr", 32'(rsp_log[0].err), 32'(ERR_EN));
      check("t5_wlat", 32'(rsp_log[0].rsp_cyc - rsp_log[0].acc_cyc), 32'd3);
      check("t5_rerr", 32'(rsp_log[1].err), 32'h0);
      check("t5_rdata", rsp_log[1].rdata, 32'hC0DE_0004);
      check("t5_rlat", 32'(rsp_log[1].rsp_cyc - rsp_log[1].acc_cyc), ERR_EN ? 32'd4 : 32'd3);
    end

    // reset while a write is in data phase and a read in address phase
    start_test();
    push(1'b1, 2'd2, 32'h0000_0020, 32'h1234_5678, 0, 1'b0);
    push(1'b0, 2'd2, 32'h0000_0024, 32'h0, 0, 1'b0);
    n = 0;
    do begin
      @(negedge hclk);
      #3;
      n++;
    end while (!(dp_v && issue_q.size() > 0) && n < 20);
    check("t6_reached", 32'(dp_v && issue_q.size() > 0), 32'h1);
    hreset_n = 1'b0;
    #1;
    check("t6_htrans", 32'(bus.htrans), 32'h0);
    check("t6_haddr", bus.haddr, 32'h0);
    check("t6_hwrite", 32'(bus.hwrite), 32'h0);
    check("t6_hsize", 32'(bus.hsize), 32'h0);
    check("t6_hwdata", bus.hwdata, 32'h0);
    check("t6_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    check("t6_rsp_rdata", bus.rsp_rdata, 32'h0);
    check("t6_rsp_err", 32'(bus.rsp_err), 32'h0);
    @(negedge hclk);
    #2 hreset_n = 1'b1;
    repeat (5) @(posedge hclk);
    check("t6_no_rsp", 32'(rsp_log.size()), 32'd0);

    // first request after reset behaves as the very first one
    start_test();
    push(1'b0, 2'd2, 32'h0000_0010, 32'h0, 0, 1'b0);
    wait_idle();
    check("t7_count", 32'(rsp_log.size()), 32'd1);
    if (rsp_log.size() >= 1) begin
      check("t7_rdata", rsp_log[0].rdata, 32'hDEAD_BEEF);
      check("t7_latency", 32'(rsp_log[0].rsp_cyc - rsp_log[0].acc_cyc), 32'd2);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

endmodule
